// File: rtl/id_queue_stage.sv
// id_queue_stage
//   Instruction-decode stage between IF and EX. Fetched instructions are
//   buffered in a DEPTH-entry queue. The head entry is decoded
//   combinationally, and its operands are resolved through NUM_FWD
//   forwarding channels. Load-use hazards are checked against the
//   instruction in EX. Decoded instructions are handed to EX through a
//   registered valid/ready output slot.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid_i/in_ready_o       IF push handshake (inst_addr_i, inst_data_i)
//   flush_i                     drop queue contents and output slot
//   reg_read_*                  two regfile read ports (address/enable out, data in)
//   fwd_en_i/addr_i/data_i      forwarding channels, channel 0 has highest priority
//   ex_is_load_i/ex_wr_addr_i   load in EX, used for load-use detection
//   out_valid_o/out_ready_i     EX handshake for the decoded fields
//   queue_count_o, stall_cnt_o  occupancy and saturating load-use stall count
module id_queue_stage #(
    parameter int DEPTH     = 4,
    parameter int NUM_FWD   = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ALU_OP_W  = 8,
    parameter int ALU_SEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ADDR_W-1:0]         inst_addr_i,
    input  logic [31:0]               inst_data_i,
    input  logic                      flush_i,
    output logic [4:0]                reg_read_addr_1_o,
    output logic                      reg_read_en_1_o,
    input  logic [DATA_W-1:0]         reg_data_1_i,
    output logic [4:0]                reg_read_addr_2_o,
    output logic                      reg_read_en_2_o,
    input  logic [DATA_W-1:0]         reg_data_2_i,
    input  logic [NUM_FWD-1:0]        fwd_en_i,
    input  logic [5*NUM_FWD-1:0]      fwd_addr_i,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_data_i,
    input  logic                      ex_is_load_i,
    input  logic [4:0]                ex_wr_addr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ADDR_W-1:0]         out_inst_addr_o,
    output logic [ALU_OP_W-1:0]       alu_op_o,
    output logic [ALU_SEL_W-1:0]      alu_sel_o,
    output logic [DATA_W-1:0]         operand_1_o,
    output logic [DATA_W-1:0]         operand_2_o,
    output logic                      reg_write_en_o,
    output logic [4:0]                reg_write_addr_o,
    output logic                      is_load_o,
    output logic                      invalid_inst_o,
    output logic [$clog2(DEPTH):0]    queue_count_o,
    output logic [15:0]               stall_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Primary opcodes and SPECIAL/SPECIAL2 function codes
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;

    // ALU operation codes
    localparam logic [ALU_OP_W-1:0] A_NOP = ALU_OP_W'(8'h00), A_AND = ALU_OP_W'(8'h24);
    localparam logic [ALU_OP_W-1:0] A_OR = ALU_OP_W'(8'h25), A_XOR = ALU_OP_W'(8'h26);
    localparam logic [ALU_OP_W-1:0] A_NOR = ALU_OP_W'(8'h27), A_SLL = ALU_OP_W'(8'h7C);
    localparam logic [ALU_OP_W-1:0] A_SRL = ALU_OP_W'(8'h02), A_SRA = ALU_OP_W'(8'h03);
    localparam logic [ALU_OP_W-1:0] A_MOVZ = ALU_OP_W'(8'h0A), A_MOVN = ALU_OP_W'(8'h0B);
    localparam logic [ALU_OP_W-1:0] A_SLT = ALU_OP_W'(8'h2A), A_SLTU = ALU_OP_W'(8'h2B);
    localparam logic [ALU_OP_W-1:0] A_ADD = ALU_OP_W'(8'h20), A_ADDU = ALU_OP_W'(8'h21);
    localparam logic [ALU_OP_W-1:0] A_SUB = ALU_OP_W'(8'h22), A_SUBU = ALU_OP_W'(8'h23);
    localparam logic [ALU_OP_W-1:0] A_MUL = ALU_OP_W'(8'hA9), A_CLZ = ALU_OP_W'(8'hB0);
    localparam logic [ALU_OP_W-1:0] A_CLO = ALU_OP_W'(8'hB1), A_LB = ALU_OP_W'(8'hE0);
    localparam logic [ALU_OP_W-1:0] A_LH = ALU_OP_W'(8'hE1), A_LW = ALU_OP_W'(8'hE3);
    localparam logic [ALU_OP_W-1:0] A_LBU = ALU_OP_W'(8'hE4), A_LHU = ALU_OP_W'(8'hE5);

    // Result-select codes
    localparam logic [ALU_SEL_W-1:0] S_NOP = ALU_SEL_W'(0), S_LOGIC = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] S_SHIFT = ALU_SEL_W'(2), S_MOVE = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] S_ARITH = ALU_SEL_W'(4), S_MUL = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] S_LOAD = ALU_SEL_W'(7);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Disabled port -> immediate; $0 -> zero; else lowest matching channel, else regfile.
    function automatic logic [DATA_W-1:0] resolve_operand(
        input logic en, input logic [4:0] ra, input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] imm, input logic [NUM_FWD-1:0] f_en,
        input logic [5*NUM_FWD-1:0] f_addr, input logic [DATA_W*NUM_FWD-1:0] f_data);
        logic [DATA_W-1:0] r;
        if (!en) r = imm;
        else if (ra == 5'd0) r = '0;
        else begin
            r = rf;
            // Walk from the oldest channel down so channel 0 overwrites last.
            for (int k = NUM_FWD - 1; k >= 0; k--)
                if (f_en[k] && f_addr[5*k +: 5] == ra) r = f_data[DATA_W*k +: DATA_W];
        end
        return r;
    endfunction

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [31:0]       mem_inst [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              out_valid_q, out_valid_d, out_we_q, out_we_d;
    logic              out_ld_q, out_ld_d, out_inv_q, out_inv_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ALU_OP_W-1:0]  out_op_q, out_op_d;
    logic [ALU_SEL_W-1:0] out_sel_q, out_sel_d;
    logic [DATA_W-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
    logic [4:0]        out_wa_q, out_wa_d;

    logic [31:0] head_inst;
    logic        head_valid, push, issue, hazard;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic signed [15:0] imm_s;
    logic [ALU_OP_W-1:0]  dec_op;
    logic [ALU_SEL_W-1:0] dec_sel;
    logic        dec_en1, dec_en2, dec_we, dec_ld, dec_inv, dec_movn, dec_movz, final_we;
    logic [4:0]  dec_wa;
    logic [DATA_W-1:0] dec_imm, op1, op2;

    assign head_valid = (count_q != '0);
    assign head_inst  = mem_inst[rd_ptr_q];
    assign opcode = head_inst[31:26];
    assign rs     = head_inst[25:21];
    assign rt     = head_inst[20:16];
    assign rd     = head_inst[15:11];
    assign funct  = head_inst[5:0];
    assign imm_s  = head_inst[15:0];

    always_comb begin
        dec_op = A_NOP;  dec_sel = S_NOP;  dec_en1 = 1'b0;  dec_en2 = 1'b0;
        dec_we = 1'b0;   dec_wa = 5'd0;    dec_imm = '0;    dec_ld = 1'b0;
        dec_inv = 1'b0;  dec_movn = 1'b0;  dec_movz = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                dec_en1 = 1'b1; dec_en2 = 1'b1; dec_we = 1'b1; dec_wa = rd;
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        // Shift amount travels as operand_1 instead of rs.
                        dec_en1 = 1'b0;
                        dec_imm = DATA_W'(head_inst[10:6]);
                        dec_sel = S_SHIFT;
                        dec_op  = (funct == 6'h00) ? A_SLL : (funct == 6'h02) ? A_SRL : A_SRA;
                    end
                    6'h04: begin dec_sel = S_SHIFT; dec_op = A_SLL; end
                    6'h06: begin dec_sel = S_SHIFT; dec_op = A_SRL; end
                    6'h07: begin dec_sel = S_SHIFT; dec_op = A_SRA; end
                    6'h0A: begin dec_sel = S_MOVE; dec_op = A_MOVZ; dec_movz = 1'b1; end
                    6'h0B: begin dec_sel = S_MOVE; dec_op = A_MOVN; dec_movn = 1'b1; end
                    6'h20: begin dec_sel = S_ARITH; dec_op = A_ADD;  end
                    6'h21: begin dec_sel = S_ARITH; dec_op = A_ADDU; end
                    6'h22: begin dec_sel = S_ARITH; dec_op = A_SUB;  end
                    6'h23: begin dec_sel = S_ARITH; dec_op = A_SUBU; end
                    6'h24: begin dec_sel = S_LOGIC; dec_op = A_AND;  end
                    6'h25: begin dec_sel = S_LOGIC; dec_op = A_OR;   end
                    6'h26: begin dec_sel = S_LOGIC; dec_op = A_XOR;  end
                    6'h27: begin dec_sel = S_LOGIC; dec_op = A_NOR;  end
                    6'h2A: begin dec_sel = S_ARITH; dec_op = A_SLT;  end
                    6'h2B: begin dec_sel = S_ARITH; dec_op = A_SLTU; end
                    default: begin
                        dec_en1 = 1'b0; dec_en2 = 1'b0; dec_we = 1'b0; dec_wa = 5'd0;
                        dec_inv = 1'b1;
                    end
                endcase
            end
            OP_SPECIAL2: begin
                dec_en1 = 1'b1; dec_we = 1'b1; dec_wa = rd;
                case (funct)
                    6'h02: begin dec_en2 = 1'b1; dec_sel = S_MUL; dec_op = A_MUL; end
                    6'h20: begin dec_sel = S_ARITH; dec_op = A_CLZ; end
                    6'h21: begin dec_sel = S_ARITH; dec_op = A_CLO; end
                    default: begin
                        dec_en1 = 1'b0; dec_we = 1'b0; dec_wa = 5'd0; dec_inv = 1'b1;
                    end
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec_en1 = 1'b1; dec_we = 1'b1; dec_wa = rt; dec_sel = S_LOGIC;
                dec_imm = (opcode == OP_LUI) ? DATA_W'({head_inst[15:0], 16'h0})
                                             : DATA_W'(head_inst[15:0]);
                dec_op  = (opcode == OP_ANDI) ? A_AND : (opcode == OP_XORI) ? A_XOR : A_OR;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_en1 = 1'b1; dec_we = 1'b1; dec_wa = rt; dec_sel = S_ARITH;
                dec_imm = DATA_W'(imm_s);
                dec_op  = (opcode == OP_ADDI) ? A_ADD : (opcode == OP_ADDIU) ? A_ADDU :
                          (opcode == OP_SLTI) ? A_SLT : A_SLTU;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec_en1 = 1'b1; dec_we = 1'b1; dec_wa = rt; dec_sel = S_LOAD; dec_ld = 1'b1;
                dec_imm = DATA_W'(imm_s);
                dec_op  = (opcode == OP_LB) ? A_LB : (opcode == OP_LH) ? A_LH :
                          (opcode == OP_LW) ? A_LW : (opcode == OP_LBU) ? A_LBU : A_LHU;
            end
            default: dec_inv = 1'b1;
        endcase
    end

    assign op1 = resolve_operand(dec_en1, rs, reg_data_1_i, dec_imm, fwd_en_i, fwd_addr_i, fwd_data_i);
    assign op2 = resolve_operand(dec_en2, rt, reg_data_2_i, dec_imm, fwd_en_i, fwd_addr_i, fwd_data_i);
    assign final_we = dec_movn ? (op2 != '0) : dec_movz ? (op2 == '0) : dec_we;

    assign hazard = head_valid && ex_is_load_i && (ex_wr_addr_i != 5'd0) &&
                    ((dec_en1 && rs == ex_wr_addr_i) || (dec_en2 && rt == ex_wr_addr_i));
    assign in_ready_o = (count_q < DEPTH_C);
    assign push  = in_valid_i && in_ready_o && !flush_i;
    assign issue = head_valid && !hazard && (!out_valid_q || out_ready_i) && !flush_i;

    always_comb begin
        wr_ptr_d = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = issue ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(issue);
        stall_cnt_d = hazard ? sat_inc16(stall_cnt_q) : stall_cnt_q;
        out_valid_d = out_valid_q; out_addr_d = out_addr_q; out_op_d = out_op_q;
        out_sel_d = out_sel_q;     out_op1_d = out_op1_q;   out_op2_d = out_op2_q;
        out_we_d = out_we_q;       out_wa_d = out_wa_q;     out_ld_d = out_ld_q;
        out_inv_d = out_inv_q;
        if (flush_i) begin
            wr_ptr_d = '0; rd_ptr_d = '0; count_d = '0; out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;     out_addr_d = mem_addr[rd_ptr_q];
            out_op_d = dec_op;      out_sel_d = dec_sel;
            out_op1_d = op1;        out_op2_d = op2;
            out_we_d = final_we;    out_wa_d = dec_wa;
            out_ld_d = dec_ld;      out_inv_d = dec_inv;
        end else if (!out_valid_q || out_ready_i) begin
            // Slot drained with nothing issuable: hazard bubble or empty queue.
            out_valid_d = 1'b0;
        end
    end

    // Queue storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= inst_addr_i;
            mem_inst[wr_ptr_q] <= inst_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;  stall_cnt_q <= '0;
            out_valid_q <= 1'b0; out_addr_q <= '0; out_op_q <= '0;  out_sel_q <= '0;
            out_op1_q <= '0;  out_op2_q <= '0;  out_we_q <= 1'b0;  out_wa_q <= '0;
            out_ld_q <= 1'b0; out_inv_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
            stall_cnt_q <= stall_cnt_d;
            out_valid_q <= out_valid_d; out_addr_q <= out_addr_d; out_op_q <= out_op_d;
            out_sel_q <= out_sel_d;  out_op1_q <= out_op1_d;  out_op2_q <= out_op2_d;
            out_we_q <= out_we_d;    out_wa_q <= out_wa_d;    out_ld_q <= out_ld_d;
            out_inv_q <= out_inv_d;
        end
    end

    assign reg_read_addr_1_o = rs;
    assign reg_read_addr_2_o = rt;
    assign reg_read_en_1_o   = head_valid && dec_en1;
    assign reg_read_en_2_o   = head_valid && dec_en2;
    assign out_valid_o       = out_valid_q;
    assign out_inst_addr_o   = out_addr_q;
    assign alu_op_o          = out_op_q;
    assign alu_sel_o         = out_sel_q;
    assign operand_1_o       = out_op1_q;
    assign operand_2_o       = out_op2_q;
    assign reg_write_en_o    = out_we_q;
    assign reg_write_addr_o  = out_wa_q;
    assign is_load_o         = out_ld_q;
    assign invalid_inst_o    = out_inv_q;
    assign queue_count_o     = count_q;
    assign stall_cnt_o       = stall_cnt_q;
endmodule

// File: tb/tb_id_queue_stage.sv
// tb_id_queue_stage
//   Directed bench for id_queue_stage (DEPTH=4, NUM_FWD=2). The regfile is
//   modelled as data = 32'hA000_0000 | address, so every regfile-sourced
//   operand can be predicted by hand.
module tb_id_queue_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst_addr, inst_data, out_addr;
    logic [4:0]  ra1, ra2, wa, ex_wr;
    logic        re1, re2, we, is_load, invalid, ex_is_load;
    logic [31:0] rd1, rd2, op1, op2;
    logic [1:0]  fwd_en;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [7:0]  alu_op;
    logic [2:0]  alu_sel;
    logic [2:0]  count;
    logic [15:0] stall;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rd1 = 32'hA000_0000 | {27'd0, ra1};
    assign rd2 = 32'hA000_0000 | {27'd0, ra2};

    id_queue_stage #(.DEPTH(4), .NUM_FWD(2), .DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_addr_i(inst_addr), .inst_data_i(inst_data), .flush_i(flush),
        .reg_read_addr_1_o(ra1), .reg_read_en_1_o(re1), .reg_data_1_i(rd1),
        .reg_read_addr_2_o(ra2), .reg_read_en_2_o(re2), .reg_data_2_i(rd2),
        .fwd_en_i(fwd_en), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
        .ex_is_load_i(ex_is_load), .ex_wr_addr_i(ex_wr),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_inst_addr_o(out_addr),
        .alu_op_o(alu_op), .alu_sel_o(alu_sel), .operand_1_o(op1), .operand_2_o(op2),
        .reg_write_en_o(we), .reg_write_addr_o(wa), .is_load_o(is_load),
        .invalid_inst_o(invalid), .queue_count_o(count), .stall_cnt_o(stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0; inst_addr = 0; inst_data = 0;
        fwd_en = 0; fwd_addr = 0; fwd_data = 0; ex_is_load = 0; ex_wr = 0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (stall !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (op1 !== 32'd0 || alu_op !== 8'd0) begin errors++; $display("FAIL reset_outs got %h/%h exp 0/0", op1, alu_op); end
        rst = 1'b0;
        tick();
    endtask

    // ORI $1,$0,0x1234 three times, EX always ready.
    task automatic test_ori();
        out_ready = 1; in_valid = 1; inst_data = 32'h3401_1234; inst_addr = 32'h100;
        tick();
        checks++; if (count !== 3'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL ori_first count=%0d valid=%0b exp 1/0", count, out_valid); end
        inst_addr = 32'h104;
        tick();
        checks++; if (out_valid !== 1'b1 || out_addr !== 32'h100) begin errors++; $display("FAIL ori_issue valid=%0b addr=%h exp 1/100", out_valid, out_addr); end
        checks++; if (op2 !== 32'h0000_1234 || op1 !== 32'd0) begin errors++; $display("FAIL ori_ops got %h/%h exp 0/1234", op1, op2); end
        checks++; if (wa !== 5'd1 || we !== 1'b1 || alu_op !== 8'h25 || alu_sel !== 3'd1) begin errors++; $display("FAIL ori_fields wa=%0d we=%0b op=%h sel=%0d exp 1/1/25/1", wa, we, alu_op, alu_sel); end
        inst_addr = 32'h108;
        tick();
        in_valid = 0;
        checks++; if (out_addr !== 32'h104 || count !== 3'd1) begin errors++; $display("FAIL ori_second addr=%h count=%0d exp 104/1", out_addr, count); end
        tick();
        checks++; if (out_addr !== 32'h108 || count !== 3'd0) begin errors++; $display("FAIL ori_third addr=%h count=%0d exp 108/0", out_addr, count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ori_drain got %0b exp 0", out_valid); end
    endtask

    // EX stalled: one entry sits in the output slot, four fill the queue, the sixth is refused.
    task automatic test_fill();
        out_ready = 0; in_valid = 1; inst_data = 32'h3402_0001;
        for (int i = 0; i < 6; i++) begin
            inst_addr = 32'h200 + 32'(4 * i);
            tick();
        end
        in_valid = 0;
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full count=%0d ready=%0b exp 4/0", count, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_addr !== 32'h200) begin errors++; $display("FAIL fill_hold valid=%0b addr=%h exp 1/200", out_valid, out_addr); end
        out_ready = 1;
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_addr !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL fill_order%0d valid=%0b addr=%h exp 1/%h", i, out_valid, out_addr, 32'h200 + 32'(4 * i)); end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fill_drop valid=%0b count=%0d exp 0/0", out_valid, count); end
    endtask

    task automatic test_forwarding();
        out_ready = 1;
        // ADDU $3,$1,$2; both channels carry $1, channel 0 must win.
        fwd_en = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'd7, 32'd5};
        in_valid = 1; inst_data = 32'h0022_1821; inst_addr = 32'h400;
        tick();
        in_valid = 0;
        checks++; if (ra1 !== 5'd1 || ra2 !== 5'd2 || re1 !== 1'b1 || re2 !== 1'b1) begin errors++; $display("FAIL fwd_read ra=%0d/%0d en=%0b%0b exp 1/2 11", ra1, ra2, re1, re2); end
        tick();
        checks++; if (op1 !== 32'd5) begin errors++; $display("FAIL fwd_priority got %h exp 5", op1); end
        checks++; if (op2 !== 32'hA000_0002 || wa !== 5'd3) begin errors++; $display("FAIL fwd_regfile op2=%h wa=%0d exp a0000002/3", op2, wa); end
        // ADDU $3,$0,$2; $0 ignores a channel targeting it, $2 comes from channel 1.
        fwd_addr = {5'd2, 5'd0}; fwd_data = {32'd9, 32'h0000_DEAD};
        in_valid = 1; inst_data = 32'h0002_1821; inst_addr = 32'h404;
        tick();
        in_valid = 0;
        tick();
        checks++; if (op1 !== 32'd0 || op2 !== 32'd9) begin errors++; $display("FAIL fwd_zero_ch1 got %h/%h exp 0/9", op1, op2); end
        fwd_en = 0;
        tick();
    endtask

    // ADDU $4,$3,$0 behind a load writing $3 for one cycle.
    task automatic test_hazard();
        out_ready = 1; in_valid = 1; inst_data = 32'h0060_2021; inst_addr = 32'h600;
        tick();
        in_valid = 0; ex_is_load = 1; ex_wr = 5'd3;
        tick();
        ex_is_load = 0; ex_wr = 0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL hazard_bubble valid=%0b count=%0d exp 0/1", out_valid, count); end
        checks++; if (stall !== 16'd1) begin errors++; $display("FAIL hazard_stall got %0d exp 1", stall); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_addr !== 32'h600 || op1 !== 32'hA000_0003) begin errors++; $display("FAIL hazard_release valid=%0b addr=%h op1=%h exp 1/600/a0000003", out_valid, out_addr, op1); end
        checks++; if (stall !== 16'd1) begin errors++; $display("FAIL hazard_stall_hold got %0d exp 1", stall); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; inst_data = 32'h3403_0003;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'h300 + 32'(4 * i);
            tick();
        end
        checks++; if (count !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre count=%0d valid=%0b exp 3/1", count, out_valid); end
        inst_addr = 32'h310; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear count=%0d valid=%0b exp 0/0", count, out_valid); end
        out_ready = 1;
        tick(); tick();
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost count=%0d valid=%0b exp 0/0", count, out_valid); end
    endtask

    task automatic test_decode();
        out_ready = 1; in_valid = 1; inst_data = 32'hFC00_0000; inst_addr = 32'h500;
        tick();
        checks++; if (re1 !== 1'b0 || re2 !== 1'b0) begin errors++; $display("FAIL dec_inv_reads got %0b%0b exp 00", re1, re2); end
        inst_data = 32'h0005_1100; inst_addr = 32'h504;   // SLL $2,$5,4
        tick();
        checks++; if (invalid !== 1'b1 || we !== 1'b0 || alu_op !== 8'h00) begin errors++; $display("FAIL dec_invalid inv=%0b we=%0b op=%h exp 1/0/00", invalid, we, alu_op); end
        checks++; if (re1 !== 1'b0 || re2 !== 1'b1 || ra2 !== 5'd5) begin errors++; $display("FAIL dec_sll_reads en=%0b%0b ra2=%0d exp 01/5", re1, re2, ra2); end
        inst_data = 32'h8C27_FFFC; inst_addr = 32'h508;   // LW $7,-4($1)
        tick();
        in_valid = 0;
        checks++; if (op1 !== 32'd4 || op2 !== 32'hA000_0005) begin errors++; $display("FAIL dec_sll_ops got %h/%h exp 4/a0000005", op1, op2); end
        checks++; if (wa !== 5'd2 || we !== 1'b1 || invalid !== 1'b0 || alu_op !== 8'h7C) begin errors++; $display("FAIL dec_sll_fields wa=%0d we=%0b inv=%0b op=%h exp 2/1/0/7c", wa, we, invalid, alu_op); end
        tick();
        checks++; if (is_load !== 1'b1 || op1 !== 32'hA000_0001 || op2 !== 32'hFFFF_FFFC || wa !== 5'd7) begin errors++; $display("FAIL dec_lw ld=%0b op1=%h op2=%h wa=%0d exp 1/a0000001/fffffffc/7", is_load, op1, op2, wa); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain got %0b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_ori();
        test_fill();
        test_forwarding();
        test_hazard();
        test_flush();
        test_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
